// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRISC core: PC update encodings and datapath width.
package nrisc_pkg;

  localparam int NRISC_WIDTH = 16;

  typedef enum logic [1:0] {
    PC_CTRL_INC  = 2'd0,
    PC_CTRL_HOLD = 2'd1,
    PC_CTRL_JMP  = 2'd2,
    PC_CTRL_RET  = 2'd3
  } pc_ctrl_e;

endpackage

// File: rtl/nrisc_pc_unit_if.sv
// Control-to-PC-stage bundle: update controls in, fetch address and stack status out.
interface nrisc_pc_unit_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH) + 1;

  logic [1:0]       PC_ctrl;
  logic             PC_en;
  logic             PC_push;
  logic [WIDTH-1:0] PC_jump_addr;
  logic             PC_err_clr;
  logic [WIDTH-1:0] PC_addr;
  logic [DW-1:0]    PC_depth;
  logic             PC_full;
  logic             PC_empty;
  logic             PC_ovf;
  logic             PC_unf;

  modport master (
    output PC_ctrl, PC_en, PC_push, PC_jump_addr, PC_err_clr,
    input  PC_addr, PC_depth, PC_full, PC_empty, PC_ovf, PC_unf
  );

  modport slave (
    input  PC_ctrl, PC_en, PC_push, PC_jump_addr, PC_err_clr,
    output PC_addr, PC_depth, PC_full, PC_empty, PC_ovf, PC_unf
  );
endinterface

// File: rtl/nrisc_pc_lifo.sv
// Return-address stack: saturating LIFO, only the top entry is readable.
module nrisc_pc_lifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int DW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [DW-1:0]    depth,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DW-1:0]    count;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign wr_idx  = count[AW-1:0];
  // At count==DEPTH the low bits are zero, so the decrement lands on DEPTH-1.
  assign top_idx = count[AW-1:0] - 1'b1;

  assign full  = (count == DW'(DEPTH));
  assign empty = (count == '0);
  assign depth = count;
  assign top   = mem[top_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + 1'b1;
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/nrisc_pc_unit.sv
// Program-counter stage: PC register, next-PC mux, return stack and sticky stack-error flags.
module nrisc_pc_unit
  import nrisc_pkg::*;
#(
  parameter int               WIDTH     = NRISC_WIDTH,
  parameter int               DEPTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input logic          clk,
  input logic          rst,
  nrisc_pc_unit_if.slave bus
);

  localparam int DW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_inc;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] stk_top;
  logic [DW-1:0]    stk_depth;
  logic             stk_full;
  logic             stk_empty;
  logic             push_req;
  logic             pop_req;
  logic             ovf_set;
  logic             unf_set;
  logic             ovf;
  logic             unf;
  pc_ctrl_e         ctrl;

  assign ctrl     = pc_ctrl_e'(bus.PC_ctrl);
  assign pc_inc   = pc + 1'b1;
  assign push_req = bus.PC_en && (ctrl == PC_CTRL_JMP) && bus.PC_push;
  assign pop_req  = bus.PC_en && (ctrl == PC_CTRL_RET);
  assign ovf_set  = push_req && stk_full;
  assign unf_set  = pop_req && stk_empty;

  nrisc_pc_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_lifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_req),
    .din   (pc_inc),
    .top   (stk_top),
    .depth (stk_depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    pc_next = pc;
    if (bus.PC_en) begin
      case (ctrl)
        PC_CTRL_INC:  pc_next = pc_inc;
        PC_CTRL_HOLD: pc_next = pc;
        PC_CTRL_JMP:  pc_next = bus.PC_jump_addr;
        PC_CTRL_RET:  pc_next = stk_empty ? pc : stk_top;
        default:      pc_next = pc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_VEC;
    end else begin
      pc <= pc_next;
    end
  end

  // Set takes priority over a coincident clear so no error event is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_set)             ovf <= 1'b1;
      else if (bus.PC_err_clr) ovf <= 1'b0;
      if (unf_set)             unf <= 1'b1;
      else if (bus.PC_err_clr) unf <= 1'b0;
    end
  end

  assign bus.PC_addr  = pc;
  assign bus.PC_depth = stk_depth;
  assign bus.PC_full  = stk_full;
  assign bus.PC_empty = stk_empty;
  assign bus.PC_ovf   = ovf;
  assign bus.PC_unf   = unf;

endmodule

// File: tb/tb_nrisc_pc_unit.sv
// Directed plus randomized checks of nrisc_pc_unit against a queue-based PC/stack model.
module tb_nrisc_pc_unit;
  localparam int               W    = 16;
  localparam int               D    = 8;
  localparam logic [W-1:0]     RVEC = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [W-1:0] m_pc;
  logic [W-1:0] m_stk[$];
  logic         m_ovf;
  logic         m_unf;

  nrisc_pc_unit_if #(.WIDTH(W), .DEPTH(D)) bus ();

  nrisc_pc_unit #(.WIDTH(W), .DEPTH(D), .RESET_VEC(RVEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    chk({tag, ".addr"},  32'(bus.PC_addr),  32'(m_pc));
    chk({tag, ".depth"}, 32'(bus.PC_depth), 32'(m_stk.size()));
    chk({tag, ".full"},  32'(bus.PC_full),  32'(m_stk.size() == D));
    chk({tag, ".empty"}, 32'(bus.PC_empty), 32'(m_stk.size() == 0));
    chk({tag, ".ovf"},   32'(bus.PC_ovf),   32'(m_ovf));
    chk({tag, ".unf"},   32'(bus.PC_unf),   32'(m_unf));
  endtask

  task automatic model_reset();
    m_pc  = RVEC;
    m_stk.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One strobe: drive, clock, advance the model, then sample 1 time unit after the edge.
  task automatic step(string tag, logic en, logic [1:0] ctrl, logic push,
                      logic [W-1:0] addr, logic clr);
    logic set_o, set_u;
    bus.PC_en        = en;
    bus.PC_ctrl      = ctrl;
    bus.PC_push      = push;
    bus.PC_jump_addr = addr;
    bus.PC_err_clr   = clr;
    @(posedge clk);
    set_o = 1'b0;
    set_u = 1'b0;
    if (en) begin
      if (ctrl == 2'd0) m_pc = m_pc + 16'd1;
      else if (ctrl == 2'd2) begin
        if (push) begin
          if (m_stk.size() < D) m_stk.push_back(m_pc + 16'd1);
          else set_o = 1'b1;
        end
        m_pc = addr;
      end else if (ctrl == 2'd3) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else set_u = 1'b1;
      end
    end
    m_ovf = set_o ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = set_u ? 1'b1 : (clr ? 1'b0 : m_unf);
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.PC_en = 0; bus.PC_ctrl = 0; bus.PC_push = 0;
    bus.PC_jump_addr = '0; bus.PC_err_clr = 0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 3; i++) step("inc", 1, 2'd0, 0, '0, 0);
    for (int i = 0; i < 3; i++)
      step("en0_hold", 0, 2'($urandom_range(0, 3)), 1'($urandom), 16'($urandom), 0);

    step("jmp_fffe", 1, 2'd2, 0, 16'hFFFE, 0);
    step("inc_ffff", 1, 2'd0, 0, '0, 0);
    step("inc_wrap", 1, 2'd0, 0, '0, 0);

    step("jmp_0010", 1, 2'd2, 0, 16'h0010, 0);
    step("call_0200", 1, 2'd2, 1, 16'h0200, 0);
    step("ret_0011", 1, 2'd3, 0, '0, 0);
    step("push_ign", 1, 2'd1, 1, 16'h1234, 0);

    for (int i = 0; i < D; i++)
      step("nest_call", 1, 2'd2, 1, 16'($urandom), 0);
    step("call_full", 1, 2'd2, 1, 16'h0400, 0);
    for (int i = 0; i < D; i++) step("nest_ret", 1, 2'd3, 0, '0, 0);
    step("clr_ovf_en0", 0, 2'd0, 0, '0, 1);

    step("jmp_0050", 1, 2'd2, 0, 16'h0050, 0);
    step("ret_empty", 1, 2'd3, 0, '0, 0);
    step("set_vs_clr", 1, 2'd3, 0, '0, 1);
    step("clr_unf", 1, 2'd1, 0, '0, 1);

    for (int i = 0; i < 400; i++)
      step("rand", 1'($urandom_range(0, 3) != 0), 2'($urandom), 1'($urandom),
           16'($urandom), 1'($urandom_range(0, 7) == 0));

    rst = 1'b0; #1; model_reset(); rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) step("pre_rst_call", 1, 2'd2, 1, 16'($urandom), 0);
    step("pre_rst_unf", 0, 2'd0, 0, '0, 0);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2;
    rst = 1'b1;
    @(negedge clk);
    check_all("rst_release");
    step("post_rst_inc", 1, 2'd0, 0, '0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
